// File: rtl/key_event_queue.sv
// rtl/key_event_queue.sv - debounced key pulses to a show-ahead FIFO of key codes
// Define KEY_DBL_EN to tag repeated presses of one key inside DBL_TIME as double presses.
module key_event_queue #(
   parameter int KEY_W    = 4,
   parameter int CODE_W   = 2,
   parameter int AW       = 3,
   parameter int DBL_TIME = 25000000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [KEY_W-1:0]  key_vld,
   output logic              evt_vld,
   input  logic              evt_rdy,
   output logic [CODE_W-1:0] evt_code,
   output logic              evt_dbl,
   output logic [AW:0]       evt_cnt,
   output logic              ovf,
   input  logic              ovf_clr
);
   localparam int DEPTH = 1 << AW;
`ifdef KEY_DBL_EN
   localparam int EW = CODE_W + 1;
   localparam int TW = $clog2(DBL_TIME + 1);
`else
   localparam int EW = CODE_W;
`endif

   logic [KEY_W-1:0]  pend_q, pend_d, sel, grant;
   logic [CODE_W-1:0] grant_code;
   logic [EW-1:0]     mem_q [DEPTH];
   logic [EW-1:0]     mem_d [DEPTH];
   logic [AW:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, cnt_q, cnt_d;
   logic              ovf_q, ovf_d;
   logic [EW-1:0]     wr_ent, head;
   logic              full, push, pop;

   // Scan from the top so the lowest pending key ends up selected.
   always_comb begin
      sel        = '0;
      grant_code = '0;
      for (int i = KEY_W - 1; i >= 0; i--) begin
         if (pend_q[i]) begin
            sel        = '0;
            sel[i]     = 1'b1;
            grant_code = CODE_W'(i);
         end
      end
   end

   assign full  = (cnt_q == (AW+1)'(DEPTH));
   assign pop   = evt_vld & evt_rdy;
   assign push  = (|pend_q) & (~full | pop);
   assign grant = push ? sel : '0;

`ifdef KEY_DBL_EN
   logic [TW-1:0]     tmr_q, tmr_d;
   logic [CODE_W-1:0] last_q, last_d;
   logic              dbl_hit;

   // tmr_q holds (cycles since last grant - 1), so a gap of exactly DBL_TIME is not a double.
   always_comb begin
      dbl_hit = (tmr_q < TW'(DBL_TIME - 1)) && (grant_code == last_q);
      tmr_d   = tmr_q;
      last_d  = last_q;
      if (push) begin
         tmr_d  = '0;
         last_d = grant_code;
      end else if (tmr_q < TW'(DBL_TIME)) begin
         tmr_d = tmr_q + TW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmr_q  <= TW'(DBL_TIME);
         last_q <= '0;
      end else begin
         tmr_q  <= tmr_d;
         last_q <= last_d;
      end
   end

   assign wr_ent  = {dbl_hit, grant_code};
   assign evt_dbl = head[EW-1];
`else
   logic unused_dbl_time;
   assign unused_dbl_time = |DBL_TIME;
   assign wr_ent  = grant_code;
   assign evt_dbl = 1'b0;
`endif

   always_comb begin
      pend_d   = (pend_q & ~grant) | key_vld;
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      ovf_d    = ovf_q;
      if (push) begin
         mem_d[wr_ptr_q[AW-1:0]] = wr_ent;
         wr_ptr_d                = wr_ptr_q + (AW+1)'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + (AW+1)'(1);
      end
      if (push && !pop) begin
         cnt_d = cnt_q + (AW+1)'(1);
      end else if (pop && !push) begin
         cnt_d = cnt_q - (AW+1)'(1);
      end
      // A press on a key already pending and not granted now is merged away.
      if (|(key_vld & pend_q & ~grant)) begin
         ovf_d = 1'b1;
      end else if (ovf_clr) begin
         ovf_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_q   <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         ovf_q    <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         pend_q   <= pend_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         ovf_q    <= ovf_d;
         mem_q    <= mem_d;
      end
   end

   assign head     = mem_q[rd_ptr_q[AW-1:0]];
   assign evt_code = head[CODE_W-1:0];
   assign evt_vld  = (cnt_q != '0);
   assign evt_cnt  = cnt_q;
   assign ovf      = ovf_q;

endmodule

// File: tb/tb_key_event_queue.sv
// tb/tb_key_event_queue.sv - vector table plus hand sequences for key_event_queue
module tb_key_event_queue;
   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] key_vld;
   logic       evt_vld, evt_rdy, evt_dbl, ovf, ovf_clr;
   logic [1:0] evt_code;
   logic [3:0] evt_cnt;
   int         n_tests = 0;
   int         n_fail = 0;

   key_event_queue #(.KEY_W(4), .CODE_W(2), .AW(3), .DBL_TIME(100)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .key_vld  (key_vld),
      .evt_vld  (evt_vld),
      .evt_rdy  (evt_rdy),
      .evt_code (evt_code),
      .evt_dbl  (evt_dbl),
      .evt_cnt  (evt_cnt),
      .ovf      (ovf),
      .ovf_clr  (ovf_clr)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] kv;
      logic       rdy;
      logic       clr;
      logic       vld;
      logic [1:0] code;
      logic [3:0] cnt;
      logic       ovf;
   } vec_t;

   vec_t       vecs[$];
   logic [2:0] evq[$];

   function automatic void add(logic [3:0] kv, logic rdy, logic clr,
                               logic vld, logic [1:0] code, logic [3:0] cnt, logic o);
      vec_t v;
      v.kv = kv; v.rdy = rdy; v.clr = clr;
      v.vld = vld; v.code = code; v.cnt = cnt; v.ovf = o;
      vecs.push_back(v);
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step(input logic [3:0] kv, input logic rdy, input logic clr);
      @(negedge clk);
      key_vld = kv;
      evt_rdy = rdy;
      ovf_clr = clr;
      @(posedge clk);
      #1;
      if (evt_vld && evt_rdy) evq.push_back({evt_dbl, evt_code});
   endtask

`ifdef KEY_DBL_EN
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(4'b0000, 1'b1, 1'b0);
   endtask

   task automatic pair(input string name, input logic [3:0] k1, input int gap,
                       input logic [3:0] k2, input logic [2:0] e0, input logic [2:0] e1);
      idle(120);
      evq.delete();
      step(k1, 1'b1, 1'b0);
      idle(gap - 1);
      step(k2, 1'b1, 1'b0);
      idle(4);
      check({name, "_count"}, evq.size(), 2);
      if (evq.size() == 2) begin
         check({name, "_ev0"}, evq[0], e0);
         check({name, "_ev1"}, evq[1], e1);
      end
   endtask
`endif

   initial begin
      rst_n   = 1'b0;
      key_vld = '0;
      evt_rdy = 1'b0;
      ovf_clr = 1'b0;

      // single press, popped immediately
      add(4'b0100, 1, 0, 0, 0, 0, 0);
      add(4'b0000, 1, 0, 1, 2, 1, 0);
      add(4'b0000, 1, 0, 0, 0, 0, 0);
      // three keys in one cycle, queued by priority then drained
      add(4'b1011, 0, 0, 0, 0, 0, 0);
      add(4'b0000, 0, 0, 1, 0, 1, 0);
      add(4'b0000, 0, 0, 1, 0, 2, 0);
      add(4'b0000, 0, 0, 1, 0, 3, 0);
      add(4'b0000, 1, 0, 1, 1, 2, 0);
      add(4'b0000, 1, 0, 1, 3, 1, 0);
      add(4'b0000, 1, 0, 0, 0, 0, 0);
      // fill with eight presses of key 2
      add(4'b0100, 0, 0, 0, 0, 0, 0);
      add(4'b0100, 0, 0, 1, 2, 1, 0);
      for (int i = 0; i < 6; i++) add(4'b0100, 0, 0, 1, 2, 4'(i + 2), 0);
      add(4'b0000, 0, 0, 1, 2, 8, 0);
      // ninth held in pend, tenth overflows, pop lets key 1 in
      add(4'b0010, 0, 0, 1, 2, 8, 0);
      add(4'b0000, 0, 0, 1, 2, 8, 0);
      add(4'b0010, 0, 0, 1, 2, 8, 1);
      add(4'b0000, 1, 0, 1, 2, 8, 1);
      // clear, then clear racing an overflow
      add(4'b0000, 0, 1, 1, 2, 8, 0);
      add(4'b0001, 0, 0, 1, 2, 8, 0);
      add(4'b0001, 0, 1, 1, 2, 8, 1);
      add(4'b0000, 0, 1, 1, 2, 8, 0);
      // drain: six 2s, then 1, then 0
      add(4'b0000, 1, 0, 1, 2, 8, 0);
      for (int i = 0; i < 5; i++) add(4'b0000, 1, 0, 1, 2, 4'(7 - i), 0);
      add(4'b0000, 1, 0, 1, 1, 2, 0);
      add(4'b0000, 1, 0, 1, 0, 1, 0);
      add(4'b0000, 1, 0, 0, 0, 0, 0);

      repeat (2) @(posedge clk);
      #1;
      check("rst_vld", evt_vld, 0);
      check("rst_code", evt_code, 0);
      check("rst_dbl", evt_dbl, 0);
      check("rst_cnt", evt_cnt, 0);
      check("rst_ovf", ovf, 0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i].kv, vecs[i].rdy, vecs[i].clr);
         n_tests++;
         if (evt_vld !== vecs[i].vld || evt_cnt !== vecs[i].cnt || ovf !== vecs[i].ovf ||
             (vecs[i].vld && evt_code !== vecs[i].code)) begin
            n_fail++;
            $display("FAIL vec%0d: vld=%0b code=%0d cnt=%0d ovf=%0b expected vld=%0b code=%0d cnt=%0d ovf=%0b",
                     i, evt_vld, evt_code, evt_cnt, ovf,
                     vecs[i].vld, vecs[i].code, vecs[i].cnt, vecs[i].ovf);
         end
      end

      // five queued events and pend=0010 when reset hits
      step(4'b1111, 1'b0, 1'b0);
      repeat (3) step(4'b0000, 1'b0, 1'b0);
      step(4'b0100, 1'b0, 1'b0);
      step(4'b0010, 1'b0, 1'b0);
      check("pre_rst_cnt", evt_cnt, 5);
      rst_n   = 1'b0;
      key_vld = '0;
      #1;
      check("mid_rst_vld", evt_vld, 0);
      check("mid_rst_code", evt_code, 0);
      check("mid_rst_cnt", evt_cnt, 0);
      check("mid_rst_ovf", ovf, 0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step(4'b0000, 1'b1, 1'b0);
         check("post_rst_idle_vld", evt_vld, 0);
      end
      step(4'b1000, 1'b1, 1'b0);
      check("lat_n1_vld", evt_vld, 0);
      step(4'b0000, 1'b1, 1'b0);
      check("lat_n2_vld", evt_vld, 1);
      check("lat_n2_code", evt_code, 3);
      step(4'b0000, 1'b1, 1'b0);
      check("lat_pop_cnt", evt_cnt, 0);

`ifdef KEY_DBL_EN
      pair("dbl50", 4'b0001, 50, 4'b0001, 3'b000, 3'b100);
      pair("dbl150", 4'b0001, 150, 4'b0001, 3'b000, 3'b000);
      pair("dbl99", 4'b0001, 99, 4'b0001, 3'b000, 3'b100);
      pair("dbl100", 4'b0001, 100, 4'b0001, 3'b000, 3'b000);
      pair("dbl_diff", 4'b0001, 10, 4'b0010, 3'b000, 3'b001);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
